// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer peripheral: register offsets and bit positions.
package bus_timer_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned PRESC_W  = 16;
  localparam int unsigned OFF_W    = 3;
  localparam int unsigned NUM_REGS = 6;

  localparam logic [OFF_W-1:0] OFF_CTRL     = 3'd0;
  localparam logic [OFF_W-1:0] OFF_PERIOD   = 3'd1;
  localparam logic [OFF_W-1:0] OFF_COUNT    = 3'd2;
  localparam logic [OFF_W-1:0] OFF_PRESC_LO = 3'd3;
  localparam logic [OFF_W-1:0] OFF_PRESC_HI = 3'd4;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd5;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned STATUS_FLAG  = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running reloadable down-counter; tick_c is high for the cycle the counter sits at zero.
module timer_prescaler
  import bus_timer_pkg::*;
#(
  parameter logic [PRESC_W-1:0] RST_VAL = 16'd49999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] reload,
  input  logic               clear,
  output logic               tick_c
);

  logic [PRESC_W-1:0] cnt;

  assign tick_c = enable && (cnt == '0);

  // A new reload value is only picked up on wrap or on an explicit clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RST_VAL;
    end else if (clear || tick_c) begin
      cnt <= reload;
    end else if (enable) begin
      cnt <= cnt - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped period timer with level IRQ on the shared 8-bit bus.
// Define BUS_TIMER_ONESHOT_EN to implement the CTRL.ONESHOT bit.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 8'hF0,
  parameter logic [PRESC_W-1:0] PRESC_RST = 16'd49999
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic              BUS_WE,
  output logic              IRQ
);

  logic              en;
  logic              irq_en;
  logic              oneshot;
  logic [DATA_W-1:0] period;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] presc_lo;
  logic [DATA_W-1:0] presc_hi;
  logic              flag;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] offset_c;
  logic [OFF_W-1:0]  off_c;
  logic              in_win_c;
  logic              wr_c;
  logic              rd_c;
  logic              wr_ctrl_c;
  logic              wr_count_c;
  logic              wr_status_c;
  logic              tick_c;
  logic              tick_eff_c;
  logic              match_c;
  logic [DATA_W-1:0] rd_mux_c;

  // Window decode; the subtraction wraps so addresses below BASE_ADDR fall outside.
  assign offset_c    = BUS_ADDR - BASE_ADDR;
  assign in_win_c    = offset_c < ADDR_W'(NUM_REGS);
  assign off_c       = offset_c[OFF_W-1:0];
  assign wr_c        = BUS_WE && in_win_c;
  assign rd_c        = !BUS_WE && in_win_c;
  assign wr_ctrl_c   = wr_c && (off_c == OFF_CTRL);
  assign wr_count_c  = wr_c && (off_c == OFF_COUNT);
  assign wr_status_c = wr_c && (off_c == OFF_STATUS);

  // A CTRL write that drops EN swallows a coincident tick.
  assign tick_eff_c = tick_c && !(wr_ctrl_c && !BUS_DATA[CTRL_EN]);
  assign match_c    = tick_eff_c && !wr_count_c && (count == period);

  timer_prescaler #(
    .RST_VAL(PRESC_RST)
  ) u_presc (
    .clk   (CLK),
    .reset (RESET),
    .enable(en),
    .reload({presc_hi, presc_lo}),
    .clear (wr_count_c),
    .tick_c(tick_c)
  );

`ifdef BUS_TIMER_ONESHOT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      oneshot <= 1'b0;
    end else if (wr_ctrl_c) begin
      oneshot <= BUS_DATA[CTRL_ONESHOT];
    end
  end
`else
  assign oneshot = 1'b0;
`endif

  always_comb begin
    rd_mux_c = '0;
    case (off_c)
      OFF_CTRL: begin
        rd_mux_c[CTRL_EN]      = en;
        rd_mux_c[CTRL_IRQ_EN]  = irq_en;
        rd_mux_c[CTRL_ONESHOT] = oneshot;
      end
      OFF_PERIOD:   rd_mux_c = period;
      OFF_COUNT:    rd_mux_c = count;
      OFF_PRESC_LO: rd_mux_c = presc_lo;
      OFF_PRESC_HI: rd_mux_c = presc_hi;
      OFF_STATUS:   rd_mux_c[STATUS_FLAG] = flag;
      default:      rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      period   <= 8'hFF;
      count    <= '0;
      presc_lo <= PRESC_RST[7:0];
      presc_hi <= PRESC_RST[15:8];
      flag     <= 1'b0;
      IRQ      <= 1'b0;
      rd_en    <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_ctrl_c) begin
        en     <= BUS_DATA[CTRL_EN];
        irq_en <= BUS_DATA[CTRL_IRQ_EN];
      end
      if (match_c && oneshot) begin
        en <= 1'b0;
      end
      if (wr_c && (off_c == OFF_PERIOD))   period   <= BUS_DATA;
      if (wr_c && (off_c == OFF_PRESC_LO)) presc_lo <= BUS_DATA;
      if (wr_c && (off_c == OFF_PRESC_HI)) presc_hi <= BUS_DATA;

      // Software clear of COUNT beats a coincident tick.
      if (wr_count_c) begin
        count <= '0;
      end else if (tick_eff_c) begin
        count <= (count == period) ? '0 : count + DATA_W'(1);
      end

      // Hardware set beats a coincident software clear.
      if (match_c) begin
        flag <= 1'b1;
      end else if (wr_status_c && BUS_DATA[STATUS_FLAG]) begin
        flag <= 1'b0;
      end

      IRQ   <= flag && irq_en;
      rd_en <= rd_c;
      if (rd_c) begin
        rd_data <= rd_mux_c;
      end
    end
  end

  assign BUS_DATA = rd_en ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: one bus transaction per clock, outputs sampled at the falling edge.
module tb_bus_timer;
  import bus_timer_pkg::*;

  localparam logic [7:0] BASE = 8'hF0;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic       we;
  logic       drv_en;
  logic [7:0] drv_data;
  wire  [7:0] bus_data;
  logic       irq;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] cseq [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01};
  logic       iseq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  assign bus_data = drv_en ? drv_data : 8'hzz;

  bus_timer #(
    .BASE_ADDR(BASE),
    .PRESC_RST(16'd49999)
  ) dut (
    .CLK     (clk),
    .RESET   (reset),
    .BUS_DATA(bus_data),
    .BUS_ADDR(addr),
    .BUS_WE  (we),
    .IRQ     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, let the rising edge take it, return at the next falling edge.
  task automatic bus_cycle(input logic [7:0] a, input logic w, input logic [7:0] d);
    addr     = a;
    we       = w;
    drv_en   = w;
    drv_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    bus_cycle(BASE + 8'(off), 1'b1, d);
  endtask

  // Read issued this cycle; its data is on the bus in the cycle that follows.
  task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string tag);
    bus_cycle(BASE + 8'(off), 1'b0, 8'h00);
    check(tag, bus_data, exp);
  endtask

  task automatic idle();
    bus_cycle(8'hFF, 1'b0, 8'h00);
  endtask

  initial begin
    reset    = 1'b1;
    addr     = 8'hFF;
    we       = 1'b0;
    drv_en   = 1'b0;
    drv_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values, back-to-back reads.
    check("rst_irq", {7'b0, irq}, 8'h00);
    rd(OFF_CTRL,     8'h00, "rst_ctrl");
    rd(OFF_PERIOD,   8'hFF, "rst_period");
    rd(OFF_COUNT,    8'h00, "rst_count");
    rd(OFF_PRESC_LO, 8'h4F, "rst_presc_lo");
    rd(OFF_PRESC_HI, 8'hC3, "rst_presc_hi");
    rd(OFF_STATUS,   8'h00, "rst_status");
    idle();
    // Bus must be released when idle: a bench-driven 00 must read back unchanged.
    addr     = 8'hFF;
    we       = 1'b0;
    drv_en   = 1'b1;
    drv_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("idle_release", bus_data, 8'h00);
    bus_cycle(8'hF8, 1'b1, 8'h77);
    rd(OFF_PERIOD, 8'hFF, "out_of_window_wr");
    idle();

    // Tick every cycle, PERIOD 3.
    wr(OFF_PRESC_LO, 8'h00);
    wr(OFF_PRESC_HI, 8'h00);
    wr(OFF_PERIOD,   8'h03);
    wr(OFF_COUNT,    8'h00);
    wr(OFF_CTRL,     8'h03);
    for (int k = 0; k < 6; k++) begin
      rd(OFF_COUNT, cseq[k], $sformatf("count_seq%0d", k));
      check($sformatf("irq_seq%0d", k), {7'b0, irq}, {7'b0, iseq[k]});
    end
    idle();
    wr(OFF_CTRL, 8'h02);
    rd(OFF_COUNT, 8'h03, "tick_discard_on_disable");
    check("irq_after_stop", {7'b0, irq}, 8'h01);
    idle();
    wr(OFF_STATUS, 8'h01);
    check("irq_lags_clear", {7'b0, irq}, 8'h01);
    idle();
    check("irq_cleared", {7'b0, irq}, 8'h00);
    rd(OFF_STATUS, 8'h00, "status_cleared");
    rd(OFF_CTRL,   8'h02, "ctrl_02");
    idle();

    // Tick every third cycle, PERIOD 0.
    wr(OFF_PRESC_LO, 8'h02);
    wr(OFF_PERIOD,   8'h00);
    wr(OFF_COUNT,    8'h00);
    wr(OFF_CTRL,     8'h03);
    idle();
    rd(OFF_STATUS, 8'h00, "presc2_before_tick");
    idle();
    rd(OFF_STATUS, 8'h01, "presc2_first_tick");
    idle();
    wr(OFF_STATUS, 8'h01);
    rd(OFF_STATUS, 8'h01, "set_beats_clear");
    idle();
    idle();
    wr(OFF_STATUS, 8'h01);
    rd(OFF_STATUS, 8'h00, "presc2_no_tick");
    idle();
    wr(OFF_CTRL, 8'h00);
    rd(OFF_COUNT, 8'h00, "period0_count");
    idle();

    // COUNT write on a matching tick, then IRQ masking.
    wr(OFF_PRESC_LO, 8'h00);
    wr(OFF_PERIOD,   8'h03);
    wr(OFF_STATUS,   8'h01);
    wr(OFF_COUNT,    8'h00);
    wr(OFF_CTRL,     8'h01);
    idle();
    idle();
    idle();
    wr(OFF_COUNT, 8'h5A);
    rd(OFF_STATUS, 8'h00, "count_wr_beats_match");
    idle();
    rd(OFF_COUNT, 8'h02, "count_after_wr");
    idle();
    rd(OFF_STATUS, 8'h01, "masked_flag");
    check("masked_irq", {7'b0, irq}, 8'h00);
    idle();
    wr(OFF_CTRL, 8'h03);
    check("unmask_lag", {7'b0, irq}, 8'h00);
    idle();
    check("unmask_irq", {7'b0, irq}, 8'h01);
    wr(OFF_CTRL, 8'h00);

    // ONESHOT bit.
    wr(OFF_STATUS, 8'h01);
    wr(OFF_PERIOD, 8'h02);
    wr(OFF_COUNT,  8'h00);
`ifdef BUS_TIMER_ONESHOT_EN
    wr(OFF_CTRL, 8'h07);
    idle();
    idle();
    idle();
    rd(OFF_CTRL, 8'h06, "oneshot_ctrl");
    idle();
    rd(OFF_COUNT, 8'h00, "oneshot_count");
    idle();
    wr(OFF_STATUS, 8'h01);
    repeat (5) idle();
    rd(OFF_STATUS, 8'h00, "oneshot_no_refire");
    idle();
`else
    wr(OFF_CTRL, 8'h07);
    rd(OFF_CTRL, 8'h03, "no_oneshot_ctrl");
    idle();
    wr(OFF_CTRL, 8'h00);
`endif

    // Reset while running and mid-read.
    wr(OFF_PERIOD, 8'h01);
    wr(OFF_CTRL,   8'h03);
    repeat (4) idle();
    reset = 1'b1;
    bus_cycle(BASE + 8'(OFF_COUNT), 1'b0, 8'h00);
    reset = 1'b0;
    check("rst2_irq", {7'b0, irq}, 8'h00);
    rd(OFF_CTRL,     8'h00, "rst2_ctrl");
    rd(OFF_PERIOD,   8'hFF, "rst2_period");
    rd(OFF_PRESC_HI, 8'hC3, "rst2_presc_hi");
    rd(OFF_STATUS,   8'h00, "rst2_status");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
